// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: state encoding shared by the sequence checker and its bench
package seq_chk_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr beats inc
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seq_stream_checker.sv
// seq_stream_checker: locks onto an incrementing stream, counts and captures mismatches
module seq_stream_checker
  import seq_chk_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             locked,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);
  state_t           st;
  logic [WIDTH-1:0] exp;
  logic [GW-1:0]    good, good_nx;
  logic [BW-1:0]    bad, bad_nx;
  logic             match, bad_beat;
  assign state    = st;
  assign good_nx  = good + 1'b1;
  assign bad_nx   = bad + 1'b1;
  assign match    = in_data == exp;
  assign bad_beat = in_valid && st == LOCKED && !match;
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= HUNT;
      locked    <= 1'b0;
      exp       <= '0;
      good      <= '0;
      bad       <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bad_beat;
      if (in_valid) begin
        case (st)
          HUNT: begin
            exp  <= in_data + 1'b1;
            good <= GW'(1);
            st   <= SYNC;
          end
          SYNC: begin
            if (match) begin
              exp  <= exp + 1'b1;
              good <= good_nx;
              if (good_nx == LOCK_V) begin
                st     <= LOCKED;
                locked <= 1'b1;
                bad    <= '0;
              end
            end else begin
              exp  <= in_data + 1'b1;
              good <= GW'(1);
            end
          end
          LOCKED: begin
            // expected value free-runs through errors so a single glitch costs one count
            exp <= exp + 1'b1;
            if (match) bad <= '0;
            else begin
              bad <= bad_nx;
              if (bad_nx == LOSS_V) begin
                st     <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (bad_beat && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_exp   <= exp;
      first_err_got   <= in_data;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_rx (
    .clk(clk), .rst(rst), .inc(in_valid), .clr(clear), .cnt(rx_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_err (
    .clk(clk), .rst(rst), .inc(bad_beat), .clr(clear), .cnt(err_cnt)
  );
endmodule
